sort_scheduler: RTL and testbench

Round-robin scheduler that shares one `selection_sort` instance between several requesters. It accepts an unsorted vector from each requester and serialises the jobs onto the sorter. It drives `sortstart`, waits for `sortdone`, and returns the sorted values and positions to the requester that owned the job. It sits between the requesting datapaths and the single sorter.

---
 rtl/sort_scheduler.sv | 139 +++++++++++++
 tb/tb_sort_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_scheduler.sv
// Round-robin scheduler that time-shares one sorter between REQUESTERS datapaths.
// Optional WAIT watchdog enabled by defining SORT_SCHED_TIMEOUT_EN.
module sort_scheduler #(
  parameter int REQUESTERS     = 4,
  parameter int INPUTVALS      = 64,
  parameter int INPUTBITWIDTHS = 16,
  parameter int TIMEOUT        = 4096
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [REQUESTERS-1:0]                              req,
  input  logic [REQUESTERS*INPUTVALS*INPUTBITWIDTHS-1:0]     req_data,
  output logic [REQUESTERS-1:0]                              ack,
  output logic [INPUTVALS*INPUTBITWIDTHS-1:0]                rsp_sorted,
  output logic [INPUTVALS*($clog2(INPUTVALS)+1)-1:0]         rsp_positions,
  output logic                                               rsp_error,
  output logic                                               rsp_timeout,
  output logic                                               busy,
  output logic                                               sort_start,
  output logic [INPUTVALS*INPUTBITWIDTHS-1:0]                sort_data,
  input  logic                                               sort_done,
  input  logic [INPUTVALS*INPUTBITWIDTHS-1:0]                sort_sorted,
  input  logic [INPUTVALS*($clog2(INPUTVALS)+1)-1:0]         sort_positions,
  input  logic                                               sort_error,
  output logic [1:0]                                         fsm_state
);

  localparam int VW  = INPUTVALS * INPUTBITWIDTHS;
  localparam int LGW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  // Handshake: req is a level held until the one-cycle ack[owner] pulse; the
  // result buses are valid in the ack cycle and held until the next ack.
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_RESP} state_t;

  state_t           state, state_next;
  logic [LGW-1:0]   owner, last_grant, winner;
  logic             arb_found;
  logic [VW-1:0]    sel_data;
  logic             sort_done_q;
  logic             done_edge;
  logic             timeout_hit;

  assign fsm_state = state;
  assign done_edge = sort_done & ~sort_done_q;

  // Search starts one past the last granted requester.
  always_comb begin
    winner    = last_grant;
    arb_found = 1'b0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      if (!arb_found && req[LGW'((int'(last_grant) + i) % REQUESTERS)]) begin
        arb_found = 1'b1;
        winner    = LGW'((int'(last_grant) + i) % REQUESTERS);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (LGW'(i) == winner) sel_data = req_data[i*VW +: VW];
    end
  end

  always_comb begin
    state_next = state;
    sort_start = 1'b0;
    ack        = '0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (|req) state_next = ST_LOAD;
      ST_LOAD: begin
        sort_start = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: if (done_edge || timeout_hit) state_next = ST_RESP;
      ST_RESP: begin
        ack        = REQUESTERS'(1) << owner;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      owner         <= '0;
      last_grant    <= LGW'(REQUESTERS - 1);
      sort_data     <= '0;
      sort_done_q   <= 1'b0;
      rsp_sorted    <= '0;
      rsp_positions <= '0;
      rsp_error     <= 1'b0;
    end else begin
      state       <= state_next;
      sort_done_q <= sort_done;
      if (state == ST_IDLE && |req) begin
        owner     <= winner;
        sort_data <= sel_data;
      end
      if (state == ST_WAIT) begin
        if (done_edge) begin
          rsp_sorted    <= sort_sorted;
          rsp_positions <= sort_positions;
          rsp_error     <= sort_error;
        end else if (timeout_hit) begin
          rsp_error <= 1'b1;
        end
      end
      if (state == ST_RESP) last_grant <= owner;
    end
  end

`ifdef SORT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  assign timeout_hit = (state == ST_WAIT) && !done_edge && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == ST_LOAD)      wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (state == ST_WAIT) begin
        if (done_edge)        rsp_timeout <= 1'b0;
        else if (timeout_hit) rsp_timeout <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sort_scheduler.sv
// Directed bench for sort_scheduler; the sorter is a stub driven by the test sequence.
module tb_sort_scheduler;
  localparam int R  = 4;
  localparam int V  = 8;
  localparam int W  = 16;
  localparam int PW = 4;
  localparam int VW = V * W;
  localparam int PV = V * PW;

  logic            clk = 1'b0;
  logic            reset;
  logic [R-1:0]    req;
  logic [R*VW-1:0] req_data;
  logic [R-1:0]    ack;
  logic [VW-1:0]   rsp_sorted;
  logic [PV-1:0]   rsp_positions;
  logic            rsp_error, rsp_timeout, busy, sort_start;
  logic [VW-1:0]   sort_data;
  logic            sort_done;
  logic [VW-1:0]   sort_sorted;
  logic [PV-1:0]   sort_positions;
  logic            sort_error;
  logic [1:0]      fsm_state;

  int total = 0;
  int bad   = 0;

  sort_scheduler #(
    .REQUESTERS(R), .INPUTVALS(V), .INPUTBITWIDTHS(W), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .rsp_sorted(rsp_sorted), .rsp_positions(rsp_positions), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout), .busy(busy), .sort_start(sort_start),
    .sort_data(sort_data), .sort_done(sort_done), .sort_sorted(sort_sorted),
    .sort_positions(sort_positions), .sort_error(sort_error), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [VW-1:0] pack_v(input int a0, a1, a2, a3, a4, a5, a6, a7);
    pack_v = {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic logic [PV-1:0] pack_p(input int a0, a1, a2, a3, a4, a5, a6, a7);
    pack_p = {PW'(a7), PW'(a6), PW'(a5), PW'(a4), PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
  endfunction

  // Requester b sends b+7 down to b; its sorted result is b up to b+7.
  function automatic logic [VW-1:0] rev_vec(input int b);
    rev_vec = pack_v(b+7, b+6, b+5, b+4, b+3, b+2, b+1, b);
  endfunction

  function automatic logic [VW-1:0] fwd_vec(input int b);
    fwd_vec = pack_v(b, b+1, b+2, b+3, b+4, b+5, b+6, b+7);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (sort_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_start_seen"}, 256'(sort_start), 256'(1));
  endtask

  // One complete job: LOAD seen, fresh done edge raised in WAIT, ack checked.
  task automatic serve(input string tag, input int who, input logic [VW-1:0] data,
                       input logic [VW-1:0] res, input logic [PV-1:0] pos, input logic err);
    wait_start(tag);
    check({tag, "_sort_data"}, 256'(sort_data), 256'(data));
    step();
    sort_done = 1'b0;
    check({tag, "_no_early_ack"}, 256'(ack), 256'(0));
    step();
    step();
    sort_sorted    = res;
    sort_positions = pos;
    sort_error     = err;
    sort_done      = 1'b1;
    step();
    check({tag, "_ack"}, 256'(ack), 256'(4'b0001 << who));
    check({tag, "_sorted"}, 256'(rsp_sorted), 256'(res));
    check({tag, "_positions"}, 256'(rsp_positions), 256'(pos));
    check({tag, "_error"}, 256'(rsp_error), 256'(err));
    check({tag, "_timeout"}, 256'(rsp_timeout), 256'(0));
    step();
    check({tag, "_ack_one_cycle"}, 256'(ack), 256'(0));
  endtask

  logic [PV-1:0] rev_pos;
  int            n;

  initial begin
    rev_pos        = pack_p(7, 6, 5, 4, 3, 2, 1, 0);
    reset          = 1'b1;
    req            = '0;
    req_data       = '0;
    sort_done      = 1'b0;
    sort_sorted    = '0;
    sort_positions = '0;
    sort_error     = 1'b0;
    for (int i = 0; i < R; i++) req_data[i*VW +: VW] = rev_vec(i);
    step();
    step();
    check("rst_ack", 256'(ack), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_start", 256'(sort_start), 256'(0));
    check("rst_state", 256'(fsm_state), 256'(0));
    check("rst_sort_data", 256'(sort_data), 256'(0));
    check("rst_rsp", 256'({rsp_sorted, rsp_positions, rsp_error, rsp_timeout}), 256'(0));
    reset = 1'b0;
    step();

    // Single job for requester 2.
    req_data[2*VW +: VW] = pack_v(7, 3, 9, 1, 0, 5, 5, 2);
    req = 4'b0100;
    step();
    check("single_start", 256'(sort_start), 256'(1));
    check("single_state_load", 256'(fsm_state), 256'(1));
    check("single_busy", 256'(busy), 256'(1));
    check("single_sort_data", 256'(sort_data), 256'(pack_v(7, 3, 9, 1, 0, 5, 5, 2)));
    step();
    check("single_start_pulse", 256'(sort_start), 256'(0));
    check("single_state_wait", 256'(fsm_state), 256'(2));
    step();
    step();
    check("single_wait_no_ack", 256'(ack), 256'(0));
    sort_sorted    = pack_v(0, 1, 2, 3, 5, 5, 7, 9);
    sort_positions = pack_p(4, 3, 7, 1, 5, 6, 0, 2);
    sort_done      = 1'b1;
    step();
    check("single_ack", 256'(ack), 256'(4'b0100));
    check("single_sorted", 256'(rsp_sorted), 256'(pack_v(0, 1, 2, 3, 5, 5, 7, 9)));
    check("single_positions", 256'(rsp_positions), 256'(pack_p(4, 3, 7, 1, 5, 6, 0, 2)));
    check("single_error", 256'(rsp_error), 256'(0));
    req = 4'b0000;
    step();
    check("single_ack_drop", 256'(ack), 256'(0));
    check("single_idle", 256'(busy), 256'(0));
    check("single_hold", 256'(rsp_sorted), 256'(pack_v(0, 1, 2, 3, 5, 5, 7, 9)));
    step();
    check("single_no_rerun", 256'(sort_start), 256'(0));
    req_data[2*VW +: VW] = rev_vec(2);

    // Round robin from a fresh reset: order 0,1,2,3,0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    req = 4'b1111;
    serve("rr0", 0, rev_vec(0), fwd_vec(0), rev_pos, 1'b0);
    serve("rr1", 1, rev_vec(1), fwd_vec(1), rev_pos, 1'b1);
    serve("rr2", 2, rev_vec(2), fwd_vec(2), rev_pos, 1'b0);
    serve("rr3", 3, rev_vec(3), fwd_vec(3), rev_pos, 1'b0);
    serve("rr4", 0, rev_vec(0), fwd_vec(0), rev_pos, 1'b0);
    req = 4'b0000;
    step();
    check("rr_idle", 256'(busy), 256'(0));

    // Stale done: sort_done still high from the last job when WAIT is entered.
    req = 4'b0001;
    wait_start("stale");
    step();
    check("stale_wait1", 256'({ack, fsm_state}), 256'({4'b0000, 2'd2}));
    step();
    check("stale_wait2", 256'({ack, fsm_state}), 256'({4'b0000, 2'd2}));
    step();
    sort_done = 1'b0;
    check("stale_wait3", 256'({ack, fsm_state}), 256'({4'b0000, 2'd2}));
    step();
    check("stale_wait4", 256'(ack), 256'(0));
    sort_sorted = fwd_vec(9);
    sort_error  = 1'b0;
    sort_done   = 1'b1;
    step();
    check("stale_ack", 256'(ack), 256'(4'b0001));
    check("stale_sorted", 256'(rsp_sorted), 256'(fwd_vec(9)));
    req = 4'b0000;
    step();

    // Withdrawal: requester 1 drops req during WAIT.
    req = 4'b0010;
    wait_start("wd");
    check("wd_sort_data", 256'(sort_data), 256'(rev_vec(1)));
    step();
    req       = 4'b0000;
    sort_done = 1'b0;
    step();
    step();
    sort_sorted = fwd_vec(1);
    sort_done   = 1'b1;
    step();
    check("wd_ack", 256'(ack), 256'(4'b0010));
    check("wd_sorted", 256'(rsp_sorted), 256'(fwd_vec(1)));
    step();
    step();
    step();
    check("wd_no_second_job", 256'({busy, sort_start}), 256'(0));

`ifdef SORT_SCHED_TIMEOUT_EN
    // Watchdog: no done edge; last grant is 1 so requester 2 wins over 0.
    sort_done = 1'b0;
    req = 4'b0101;
    wait_start("to");
    check("to_sort_data", 256'(sort_data), 256'(rev_vec(2)));
    n = 0;
    while (ack === 4'b0000 && n < 200) begin
      step();
      n++;
    end
    check("to_latency", 256'(n), 256'(65));
    check("to_ack", 256'(ack), 256'(4'b0100));
    check("to_flags", 256'({rsp_timeout, rsp_error}), 256'(2'b11));
    check("to_sorted_kept", 256'(rsp_sorted), 256'(fwd_vec(1)));
    req = 4'b0001;
    serve("to_next", 0, rev_vec(0), fwd_vec(0), rev_pos, 1'b0);
    req = 4'b0000;
    step();
`endif

    // Async reset mid-WAIT, then priority restarts at requester 0.
    req = 4'b0100;
    serve("pre_rst", 2, rev_vec(2), fwd_vec(2), rev_pos, 1'b0);
    wait_start("abort");
    step();
    step();
    check("abort_in_wait", 256'(fsm_state), 256'(2));
    reset     = 1'b1;
    sort_done = 1'b0;
    #1;
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_ack", 256'(ack), 256'(0));
    check("abort_state", 256'(fsm_state), 256'(0));
    check("abort_rsp_cleared", 256'(rsp_sorted), 256'(0));
    req = 4'b0000;
    step();
    reset = 1'b0;
    step();
    step();
    check("abort_no_ack", 256'({ack, busy}), 256'(0));
    req = 4'b1001;
    serve("post_rst0", 0, rev_vec(0), fwd_vec(0), rev_pos, 1'b0);
    serve("post_rst3", 3, rev_vec(3), fwd_vec(3), rev_pos, 1'b0);
    req = 4'b0000;
    step();
    check("final_idle", 256'(busy), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
